// File: rtl/my_fetch.sv
// Instruction fetch stage: PC-driven ROM request/ack, small instruction FIFO, valid/ready to decode.
// Optional FETCH_BYPASS_EN macro forwards an ack straight to decode when the FIFO is empty.
module my_fetch #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_addr,
  output logic             pc_inc,
  input  logic             flush,
  output logic             rom_req,
  output logic [WIDTH-1:0] rom_addr,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_addr,
  output logic             instr_valid,
  input  logic             instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t             state_q, state_d;
  logic               romReq_q, romReq_d;
  logic [WIDTH-1:0]   romAddr_q, romAddr_d;
  logic [WIDTH-1:0]   dataMem_q [DEPTH];
  logic [WIDTH-1:0]   addrMem_q [DEPTH];
  logic [PTR_W-1:0]   rdPtr_q, wrPtr_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   lastInstr_q, lastAddr_q;
  logic               ackOk, fifoEmpty, bypassHit, push, pop;

  assign ackOk     = (state_q == REQ) & rom_ack & ~flush;
  assign pc_inc    = ackOk & ~reset;
  assign fifoEmpty = (count_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypassHit = ackOk & fifoEmpty;
`else
  assign bypassHit = 1'b0;
`endif

  // A bypassed word taken by decode in its ack cycle never enters the FIFO.
  assign push = ackOk & ~(bypassHit & instr_ready);
  assign pop  = ~fifoEmpty & instr_ready & ~flush;

  assign rom_req  = romReq_q;
  assign rom_addr = romAddr_q;

  always_comb begin
    instr       = lastInstr_q;
    instr_addr  = lastAddr_q;
    instr_valid = 1'b0;
    if (!fifoEmpty) begin
      instr       = dataMem_q[rdPtr_q];
      instr_addr  = addrMem_q[rdPtr_q];
      instr_valid = 1'b1;
    end else if (bypassHit) begin
      instr       = rom_data;
      instr_addr  = romAddr_q;
      instr_valid = 1'b1;
    end
  end

  // The ROM cannot abort, so a flush mid-request parks in DISCARD until the ack arrives.
  always_comb begin
    state_d   = state_q;
    romReq_d  = romReq_q;
    romAddr_d = romAddr_q;
    case (state_q)
      IDLE: begin
        if ((count_q < CNT_W'(DEPTH)) && !flush) begin
          state_d   = REQ;
          romReq_d  = 1'b1;
          romAddr_d = pc_addr;
        end
      end
      REQ: begin
        if (rom_ack) begin
          state_d  = IDLE;
          romReq_d = 1'b0;
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (rom_ack) begin
          state_d  = IDLE;
          romReq_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        romReq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      romReq_q  <= 1'b0;
      romAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      romReq_q  <= romReq_d;
      romAddr_q <= romAddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dataMem_q[wrPtr_q] <= rom_data;
      addrMem_q[wrPtr_q] <= romAddr_q;
    end
  end

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Remembers the last presented head so instr/instr_addr hold once the FIFO drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastInstr_q <= '0;
      lastAddr_q  <= '0;
    end else if (instr_valid) begin
      lastInstr_q <= instr;
      lastAddr_q  <= instr_addr;
    end
  end

endmodule

// File: doc/my_fetch.md
Name: my_fetch

Overview:
- Instruction fetch stage directly downstream of the 16-bit program counter.
- Reads the PC value, issues a request/acknowledge read to instruction ROM, and queues each returned word with its address in a small FIFO.
- Presents queued instructions to decode over a valid/ready interface.
- Drives the PC increment strobe. On a taken jump, the CPU drives the PC load directly and asserts flush here.

Parameters:
- DEPTH, 2, FIFO entries (instruction plus address); legal values 1 to 8.
- WIDTH, 16, width of instruction and address words.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state on the clk edge where it is sampled high.
- pc_addr  input  WIDTH  current PC output.
- pc_inc  output  1  combinational; drives the PC inc input.
- flush  input  1  jump taken this cycle; asserted in the same cycle the PC load is asserted.
- rom_req  output  1  read request, registered.
- rom_addr  output  WIDTH  read address, registered; stable while rom_req is high.
- rom_ack  input  1  ROM has data this cycle; legal in any cycle where rom_req is high, including the first.
- rom_data  input  WIDTH  instruction word; valid when rom_ack is high.
- instr  output  WIDTH  FIFO head instruction.
- instr_addr  output  WIDTH  address of instr.
- instr_valid  output  1  head entry valid.
- instr_ready  input  1  decode accepts head entry.

Behaviour:
- Reset values: rom_req=0, rom_addr=0, instr_valid=0, instr=0, instr_addr=0, FIFO count=0, state=IDLE. pc_inc=0 while in reset.
- FSM has three states: IDLE, REQ, DISCARD.
  - IDLE -> REQ when count<DEPTH and flush=0. On this edge: rom_addr<=pc_addr, rom_req<=1.
  - REQ with rom_ack=1 and flush=0: push {rom_data, rom_addr} into FIFO; pc_inc=1 in that cycle so the PC advances on the same edge; rom_req<=0; go to IDLE.
  - REQ with rom_ack=1 and flush=1: drop the data; pc_inc=0; go to IDLE.
  - REQ with rom_ack=0 and flush=1: keep rom_req high and rom_addr unchanged (the ROM cannot abort); go to DISCARD.
  - DISCARD with rom_ack=1: drop the data; pc_inc=0; rom_req<=0; go to IDLE. Further flushes while in DISCARD are ignored.
- Fetch cadence: at most one request outstanding; minimum 2 cycles per instruction (REQ, then IDLE). IDLE re-samples pc_addr after the increment.
- Latency: the instruction is visible on instr/instr_valid in the cycle after the ack edge.
- pc_inc equation: pc_inc = (state==REQ) & rom_ack & ~flush & ~reset. It is never asserted in any other case.
- FIFO:
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Full: count==DEPTH blocks new requests. A push into a full FIFO cannot occur, because a request is only issued when count<DEPTH.
  - Empty: instr_valid=0; instr and instr_addr hold their last values.
  - While instr_valid=1 and instr_ready=0, instr and instr_addr stay stable.
- Flush: on the flush edge, count<=0 and instr_valid<=0. Flush takes priority over a same-cycle pop or push.
- Wrap-around: addresses are unsigned modulo 2^WIDTH. 0xFFFF is followed by 0x0000; this is handled by the PC and needs no special case here.
- Reset mid-transaction: rom_req drops on the reset edge and any later rom_ack is ignored. The ROM model tolerates an abandoned request.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and state==REQ, rom_ack=1, flush=0, the block drives instr=rom_data, instr_addr=rom_addr and instr_valid=1 combinationally in the ack cycle.
  - If instr_ready=1 in that cycle, the word is consumed and not pushed.
  - Otherwise it is pushed as normal and remains at the head next cycle with identical values.
  - Latency is 0 cycles after ack.
- Undefined: no combinational path from rom_data to instr; latency is 1 cycle.

Test Plan:
- Reset, then stream: ROM acks with 0 wait states, rom[0..3]=0x1111,0x2222,0x3333,0x4444; instr_ready=1 -> instr_addr 0,1,2,3 with matching data; pc_inc pulses once per ack; PC reaches 4.
- Backpressure: instr_ready=0, DEPTH=2 -> exactly 2 entries are fetched (addresses 0,1) and rom_req stays 0 afterwards. Raising instr_ready delivers 0x1111 then 0x2222 in order, and fetching resumes at address 2.
- Flush with in-flight request: ROM wait of 3 cycles. Assert flush plus PC load=0x0100 while in REQ at address 5 -> ack at address 5 is discarded with no pc_inc and no push. Next request goes to address 0x0100, and the first delivered instr_addr is 0x0100.
- Flush while full: FIFO holds 2 entries and flush is asserted together with instr_ready=1 -> instr_valid=0 on the next cycle and no pop is observed for the stale head.
- Reset mid-request: reset in REQ at address 3, with rom_ack arriving 1 cycle later -> rom_req=0 and instr_valid=0 after the edge, and the late ack produces no push and no pc_inc.
- FETCH_BYPASS_EN: empty FIFO, ack of 0xBEEF at address 0x0007 with instr_ready=1 -> instr_valid=1 with 0xBEEF/0x0007 in the ack cycle, and FIFO count remains 0.
